// File: rtl/spart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// spart_rx_ctrl
//
// Bus-side controller for the SPART receive path. It does three jobs:
//   * generates the 16x oversample Baud tick from a programmable 16-bit divisor,
//   * captures each byte the receiver flags as ready into a small FIFO,
//   * exposes receive data, status and the divisor through a 2-bit register map.
//
// Register map (ioaddr):
//   00 RXDATA (R) : head byte of the FIFO, popped on read; 0x00 when empty
//   01 STATUS (R) : {overrun, 2'b00, count[3:0] saturated, rda}; clears overrun
//   10 DBLO   (W) : divisor low-byte staging register
//   11 DBHI   (W) : commits divisor = {bus_din, dblo_stage} and restarts the Baud
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   iocs, iorw        chip select, 1 = read / 0 = write
//   ioaddr, bus_din   register address and write data
//   bus_dout          combinational read data
//   rda               receive FIFO non-empty
//   rx_data, rx_rdy   byte and ready level from the receiver
//   baud              1-cycle Baud tick to the receiver
//   rx_rst            1-cycle receiver abort pulse, issued on every divisor commit
// -----------------------------------------------------------------------------
module spart_rx_ctrl #(
  parameter logic [15:0] DIV_DEFAULT = 16'd325,
  parameter int          FIFO_DEPTH  = 4          // power of 2, 2..16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       rda,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic       baud,
  output logic       rx_rst
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] ST_RELOAD = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]    state_q,      state_d;
  logic [15:0]   baud_cnt_q,   baud_cnt_d;
  logic [15:0]   divisor_q,    divisor_d;
  logic [7:0]    dblo_stage_q, dblo_stage_d;
  logic          rx_rdy_q,     rx_rdy_d;
  logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,     rd_ptr_d;
  logic [CW-1:0] count_q,      count_d;
  logic          overrun_q,    overrun_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic rd_data_sel, rd_stat_sel, wr_dblo, wr_dbhi;

  assign rd_data_sel = iocs &  iorw & (ioaddr == 2'b00);
  assign rd_stat_sel = iocs &  iorw & (ioaddr == 2'b01);
  assign wr_dblo     = iocs & ~iorw & (ioaddr == 2'b10);
  assign wr_dbhi     = iocs & ~iorw & (ioaddr == 2'b11);

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic fifo_empty, fifo_full, push_req, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

  // Capture only on the rising edge of the ready level, and never while the
  // receiver is being held in abort (RELOAD).
  assign push_req = rx_rdy & ~rx_rdy_q & (state_q == ST_RUN);
  assign pop      = rd_data_sel & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req & (~fifo_full | pop);

  // ---------------------------------------------------------------------------
  // Baud generator outputs; both come straight from state so reset forces them
  // to their idle values without waiting for a clock.
  // ---------------------------------------------------------------------------
  logic [15:0] div_m1;

  assign div_m1 = (divisor_q == 16'd0) ? 16'd0 : divisor_q - 16'd1;
  assign rx_rst = (state_q == ST_RELOAD);
  assign baud   = (state_q == ST_RUN) && (baud_cnt_q == 16'd0);
  assign rda    = ~fifo_empty;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [4:0] count_ext;
  logic [3:0] count_sat;

  assign count_ext = 5'(count_q);
  // The STATUS count field is 4 bits wide; a 16-deep full FIFO reports 15.
  assign count_sat = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];

  always_comb begin
    bus_dout = 8'h00;
    if (rd_data_sel && !fifo_empty) bus_dout = mem_q[rd_ptr_q];
    else if (rd_stat_sel)           bus_dout = {overrun_q, 2'b00, count_sat, rda};
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    divisor_d    = divisor_q;
    dblo_stage_d = dblo_stage_q;
    rx_rdy_d     = rx_rdy;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overrun_d    = overrun_q;

    // Divisor registers: low byte is only staged, high byte commits both.
    if (wr_dblo) dblo_stage_d = bus_din;
    if (wr_dbhi) divisor_d    = {bus_din, dblo_stage_q};

    case (state_q)
      ST_RELOAD: begin
        baud_cnt_d = div_m1;
        // A commit arriving while already reloading extends the abort a cycle.
        state_d    = wr_dbhi ? ST_RELOAD : ST_RUN;
      end
      ST_RUN: begin
        baud_cnt_d = (baud_cnt_q == 16'd0) ? div_m1 : baud_cnt_q - 16'd1;
        if (wr_dbhi) state_d = ST_RELOAD;
      end
      default: state_d = ST_RELOAD;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new overrun in the same cycle as a STATUS read wins over the clear.
    if (rd_stat_sel)   overrun_d = 1'b0;
    if (push_req && !push) overrun_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RELOAD;
      baud_cnt_q   <= '0;
      divisor_q    <= DIV_DEFAULT;
      dblo_stage_q <= DIV_DEFAULT[7:0];
      rx_rdy_q     <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      divisor_q    <= divisor_d;
      dblo_stage_q <= dblo_stage_d;
      rx_rdy_q     <= rx_rdy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_spart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spart_rx_ctrl
//
// Directed bench for spart_rx_ctrl with DIV_DEFAULT=4 and FIFO_DEPTH=4.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 1-2 units later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_spart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;
  logic       rda;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       baud;
  logic       rx_rst;

  int checks   = 0;
  int failures = 0;

  spart_rx_ctrl #(
    .DIV_DEFAULT (16'd4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .bus_din  (bus_din),
    .bus_dout (bus_dout),
    .rda      (rda),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .baud     (baud),
    .rx_rst   (rx_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s: observed=%02h expected=%02h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iocs    = 1'b0;
    iorw    = 1'b0;
    ioaddr  = 2'b00;
    bus_din = 8'h00;
  endtask

  task automatic drive_write(input logic [1:0] a, input logic [7:0] d);
    iocs    = 1'b1;
    iorw    = 1'b0;
    ioaddr  = a;
    bus_din = d;
  endtask

  // One read cycle; returns the combinational read data, then advances.
  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    iocs   = 1'b1;
    iorw   = 1'b1;
    ioaddr = a;
    #1;
    d = bus_dout;
    tick();
    idle();
  endtask

  // Rising edge on rx_rdy with byte d; the push lands on the second edge.
  task automatic push_byte(input logic [7:0] d);
    rx_rdy = 1'b0;
    tick();
    rx_data = d;
    rx_rdy  = 1'b1;
    tick();
  endtask

  // Checks baud over n RUN cycles numbered start.. relative to the reload.
  task automatic run_baud(input string tag, input int start, input int n, input int period);
    for (int i = 0; i < n; i++) begin
      chk(tag, {7'b0, baud}, (((start + i) % period) == 0) ? 8'h01 : 8'h00);
      tick();
    end
  endtask

  logic [7:0] rd;

  initial begin
    rst     = 1'b1;
    iocs    = 1'b0;
    iorw    = 1'b0;
    ioaddr  = 2'b00;
    bus_din = 8'h00;
    rx_data = 8'h00;
    rx_rdy  = 1'b1;

    // ---- Reset state ----
    #2;
    chk("rst_baud",   {7'b0, baud},   8'h00);
    chk("rst_rx_rst", {7'b0, rx_rst}, 8'h01);
    chk("rst_rda",    {7'b0, rda},    8'h00);
    chk("rst_dout",   bus_dout,       8'h00);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ---- 1: reload cycle, then period 4 ----
    chk("t1_reload_rx_rst", {7'b0, rx_rst}, 8'h01);
    chk("t1_reload_baud",   {7'b0, baud},   8'h00);
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b01;
    #1 chk("t1_status", bus_dout, 8'h00);
    tick();
    idle();
    chk("t1_run_rx_rst", {7'b0, rx_rst}, 8'h00);
    run_baud("t1_baud_p4", 1, 12, 4);

    // ---- 2: DBLO alone leaves the baud alone; DBHI commits period 10 ----
    drive_write(2'b10, 8'h0A);
    run_baud("t2_after_dblo", 13, 1, 4);
    idle();
    run_baud("t2_after_dblo", 14, 8, 4);
    drive_write(2'b11, 8'h00);
    run_baud("t2_dbhi_cycle", 22, 1, 4);
    idle();
    chk("t2_reload_rx_rst", {7'b0, rx_rst}, 8'h01);
    chk("t2_reload_baud",   {7'b0, baud},   8'h00);
    tick();
    chk("t2_run_rx_rst", {7'b0, rx_rst}, 8'h00);
    run_baud("t2_baud_p10", 1, 20, 10);

    // Divisor 0: write low 0, then high 0; repeat the DBHI inside RELOAD.
    drive_write(2'b10, 8'h00);
    run_baud("t2_baud_p10", 21, 1, 10);
    drive_write(2'b11, 8'h00);
    run_baud("t2_baud_p10", 22, 1, 10);
    rx_rdy = 1'b0;                         // DBHI still driven in RELOAD A
    chk("t2_reload_a", {7'b0, rx_rst}, 8'h01);
    tick();
    idle();
    rx_data = 8'hEE;
    rx_rdy  = 1'b1;                        // rising edge during RELOAD B
    chk("t2_reload_b", {7'b0, rx_rst}, 8'h01);
    tick();
    chk("t2_run_rx_rst_p1", {7'b0, rx_rst}, 8'h00);
    run_baud("t2_baud_p1", 1, 5, 1);
    chk("t2_reload_edge_ignored", {7'b0, rda}, 8'h00);

    // ---- 3: one held level captures once ----
    rx_rdy = 1'b0;
    tick();
    rx_data = 8'h55;
    rx_rdy  = 1'b1;
    repeat (20) tick();
    chk("t3_rda", {7'b0, rda}, 8'h01);
    bus_read(2'b01, rd);
    chk("t3_status", rd, 8'h03);
    bus_read(2'b00, rd);
    chk("t3_data", rd, 8'h55);
    chk("t3_rda_after", {7'b0, rda}, 8'h00);

    // ---- 4: overflow ----
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    bus_read(2'b01, rd);
    chk("t4_status_ovr", rd, 8'h89);
    for (int i = 1; i <= 4; i++) begin
      bus_read(2'b00, rd);
      chk("t4_data", rd, 8'(i));
    end
    bus_read(2'b00, rd);
    chk("t4_empty_read", rd, 8'h00);
    bus_read(2'b01, rd);
    chk("t4_status_clr", rd, 8'h00);

    // ---- 5: push and pop together on a full FIFO ----
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    bus_read(2'b01, rd);
    chk("t5_status_full", rd, 8'h09);
    rx_rdy = 1'b0;
    tick();
    rx_data = 8'hAA;
    rx_rdy  = 1'b1;
    bus_read(2'b00, rd);
    chk("t5_pushpop_data", rd, 8'h11);
    bus_read(2'b01, rd);
    chk("t5_status_no_ovr", rd, 8'h09);
    bus_read(2'b00, rd);
    chk("t5_data_22", rd, 8'h22);
    bus_read(2'b00, rd);
    chk("t5_data_33", rd, 8'h33);
    bus_read(2'b00, rd);
    chk("t5_data_44", rd, 8'h44);
    bus_read(2'b00, rd);
    chk("t5_data_aa", rd, 8'hAA);
    bus_read(2'b01, rd);
    chk("t5_status_empty", rd, 8'h00);

    // ---- 6: reset mid-operation ----
    push_byte(8'h66);
    push_byte(8'h77);
    chk("t6_pre_baud", {7'b0, baud}, 8'h01);
    chk("t6_pre_rda",  {7'b0, rda},  8'h01);
    bus_read(2'b11, rd);
    chk("t6_wr_addr_read", rd, 8'h00);
    bus_read(2'b01, rd);
    chk("t6_status_two", rd, 8'h05);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_baud",   {7'b0, baud},   8'h00);
    chk("t6_rst_rda",    {7'b0, rda},    8'h00);
    chk("t6_rst_rx_rst", {7'b0, rx_rst}, 8'h01);
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
    #1 chk("t6_rst_dout", bus_dout, 8'h00);
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_reload_rx_rst", {7'b0, rx_rst}, 8'h01);
    tick();
    chk("t6_run_rx_rst", {7'b0, rx_rst}, 8'h00);
    run_baud("t6_baud_p4", 1, 8, 4);
    bus_read(2'b01, rd);
    chk("t6_status_after", rd, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
